// File: rtl/pixel_stream_feeder.sv
// Line-paced pixel streamer: reads a stored frame (1-cycle read latency) and drives a
// valid/ready pixel port, releasing one further line per line-free interrupt.
module pixel_stream_feeder #(
  parameter int IMG_WIDTH  = 512,
  parameter int IMG_HEIGHT = 512,
  parameter int INIT_LINES = 4,
  parameter int ADDR_W     = 18
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [7:0]        i_rd_data,
  output logic              o_data_valid,
  output logic [7:0]        o_data,
  input  logic              i_data_ready,
  input  logic              i_interrupt
);

  localparam int XW = $clog2(IMG_WIDTH + 1);
  localparam int YW = $clog2(IMG_HEIGHT + 1);
  localparam int CW = $clog2(INIT_LINES + 2);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_WIDTH * IMG_HEIGHT - 1);
  localparam logic [XW-1:0]     LAST_COL  = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0]     LAST_LINE = YW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0]     CRED_MAX  = CW'(INIT_LINES);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_SEND     = 3'd2,
    S_WAIT_IRQ = 3'd3,
    S_DRAIN    = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CW-1:0]     r_credits;
  logic [CW-1:0]     w_cred_sum;
  logic [CW-1:0]     w_cred_nxt;
  logic [XW-1:0]     r_col;
  logic [YW-1:0]     r_lines;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_inflight;
  logic              r_valid;
  logic [7:0]        r_data;
  logic              r_skid_valid;
  logic [7:0]        r_skid_data;
  logic              r_busy;
  logic              r_done;

  logic       w_beat;
  logic [1:0] w_occ;
  logic       w_rd_en;
  logic       w_line_end;
  logic       w_has_credit;
  logic       w_consume;
  logic       w_irq_inc;
  logic       w_drained;

  // Handshake, read gating and end-of-frame detection.
  always_comb begin
    w_beat       = r_valid & i_data_ready;
    // Occupancy after this cycle's beat leaves; the output reg plus skid hold at most two.
    w_occ        = 2'(r_valid) + 2'(r_skid_valid) + 2'(r_inflight) - 2'(w_beat);
    w_rd_en      = (r_state == S_SEND) && (w_occ < 2'd2);
    w_line_end   = w_rd_en && (r_col == LAST_COL);
    w_has_credit = (r_credits != {CW{1'b0}});
    w_irq_inc    = i_interrupt && (r_state != S_IDLE);
    w_drained    = w_beat && !r_skid_valid && !r_inflight;
  end

  // Next-state logic; a line end with a credit on hand stays in SEND so no bubble appears.
  always_comb begin
    w_state_nxt = r_state;
    w_consume   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_state_nxt = S_LOAD;
        else         w_state_nxt = S_IDLE;
      end
      S_LOAD, S_WAIT_IRQ: begin
        if (w_has_credit) begin
          w_consume   = 1'b1;
          w_state_nxt = S_SEND;
        end else begin
          w_state_nxt = S_WAIT_IRQ;
        end
      end
      S_SEND: begin
        if (!w_line_end) begin
          w_state_nxt = S_SEND;
        end else if (r_lines == LAST_LINE) begin
          w_state_nxt = S_DRAIN;
        end else if (w_has_credit) begin
          w_consume   = 1'b1;
          w_state_nxt = S_SEND;
        end else begin
          w_state_nxt = S_WAIT_IRQ;
        end
      end
      S_DRAIN: begin
        if (w_drained) w_state_nxt = S_IDLE;
        else           w_state_nxt = S_DRAIN;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Credit update: an interrupt and a consume in the same cycle cancel; saturate at the ceiling.
  always_comb begin
    w_cred_sum = r_credits + CW'(w_irq_inc) - CW'(w_consume);
    if (w_cred_sum > CRED_MAX) w_cred_nxt = CRED_MAX;
    else                       w_cred_nxt = w_cred_sum;
  end

  // Control registers: state, credits, read address and line/pixel counters, status pulses.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_credits  <= {CW{1'b0}};
      r_col      <= {XW{1'b0}};
      r_lines    <= {YW{1'b0}};
      r_rd_addr  <= {ADDR_W{1'b0}};
      r_inflight <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_rd_en;
      r_done     <= (r_state == S_DRAIN) && w_drained;
      if (r_state == S_IDLE) begin
        if (i_start) begin
          r_credits <= CRED_MAX;
          r_col     <= {XW{1'b0}};
          r_lines   <= {YW{1'b0}};
          r_rd_addr <= {ADDR_W{1'b0}};
          r_busy    <= 1'b1;
        end
      end else begin
        r_credits <= w_cred_nxt;
        if ((r_state == S_DRAIN) && w_drained) r_busy <= 1'b0;
      end
      if (w_rd_en) begin
        if (r_rd_addr != LAST_ADDR) r_rd_addr <= r_rd_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
        r_col   <= (r_col == LAST_COL) ? {XW{1'b0}} : r_col + {{(XW-1){1'b0}}, 1'b1};
        r_lines <= r_lines + {{(YW-1){1'b0}}, w_line_end};
      end
    end
  end

  // Output register with one-entry skid; arriving read data is never dropped.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid      <= 1'b0;
      r_data       <= 8'd0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= 8'd0;
    end else if (w_beat || !r_valid) begin
      if (r_skid_valid) begin
        r_valid      <= 1'b1;
        r_data       <= r_skid_data;
        r_skid_valid <= r_inflight;
        if (r_inflight) r_skid_data <= i_rd_data;
      end else if (r_inflight) begin
        r_valid <= 1'b1;
        r_data  <= i_rd_data;
      end else begin
        r_valid <= 1'b0;
      end
    end else if (r_inflight) begin
      r_skid_valid <= 1'b1;
      r_skid_data  <= i_rd_data;
    end
  end

  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_rd_en      = w_rd_en;
  assign o_rd_addr    = r_rd_addr;
  assign o_data_valid = r_valid;
  assign o_data       = r_data;

endmodule

// File: tb/tb_pixel_stream_feeder.sv
// Randomized self-checking bench for pixel_stream_feeder (8x6 frame, 4 initial lines, mem[a]=a);
// expected beat counts come from a line-credit model, expected data from the beat index.
module tb_pixel_stream_feeder;
  localparam int W  = 8;
  localparam int H  = 6;
  localparam int IL = 4;
  localparam int AW = 18;

  logic          clk = 1'b0;
  logic          rst, start, ready, irq;
  logic [7:0]    rd_data;
  logic          busy, done, rd_en, dvalid;
  logic [AW-1:0] rd_addr;
  logic [7:0]    data;

  int n_checks = 0, n_fail = 0;
  int beats, done_cnt, cyc_n, last_beat_cyc, done_cyc, first_valid_cyc, gaps, m_irqs;
  bit track_gaps, prev_stall;
  logic [7:0] prev_data;

  always #5 clk = ~clk;

  pixel_stream_feeder #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .INIT_LINES(IL), .ADDR_W(AW)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .o_busy(busy), .o_done(done),
    .o_rd_en(rd_en), .o_rd_addr(rd_addr), .i_rd_data(rd_data), .o_data_valid(dvalid),
    .o_data(data), .i_data_ready(ready), .i_interrupt(irq));

  // Frame memory: one-cycle latency, garbage when not read.
  always @(posedge clk) rd_data <= rd_en ? rd_addr[7:0] : 8'($urandom);

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Credit model: lines allowed = INIT_LINES + counted irqs; an irq is dropped when the
  // outstanding credit (after this edge's line starts) is already at the ceiling.
  task automatic m_irq(input int started);
    if (IL + m_irqs - started < IL) m_irqs++;
  endtask

  function automatic int m_lines();
    return (IL + m_irqs < H) ? IL + m_irqs : H;
  endfunction

  // One clock: judge the handshake just before the edge, then sample post-edge outputs.
  task automatic cyc();
    if (prev_stall) begin
      check_eq("hold_valid", int'(dvalid), 1);
      check_eq("hold_data", int'(data), int'(prev_data));
    end
    if (dvalid && ready) begin
      check_eq("beat_data", int'(data), beats % 256);
      beats++;
      last_beat_cyc = cyc_n;
    end else if (track_gaps && !dvalid && beats > 0 && beats < m_lines() * W) begin
      gaps++;
    end
    prev_stall = dvalid && !ready;
    prev_data  = data;
    @(posedge clk);
    @(negedge clk);
    cyc_n++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc_n;
    end
    if (dvalid && first_valid_cyc < 0) first_valid_cyc = cyc_n;
  endtask

  task automatic new_frame();
    beats = 0; done_cnt = 0; m_irqs = 0; gaps = 0; prev_stall = 1'b0;
    cyc_n = 0; first_valid_cyc = -1; last_beat_cyc = -100; done_cyc = -1;
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic run_until(input int target, input int budget);
    for (int i = 0; i < budget && beats < target; i++) cyc();
  endtask

  // Run to o_done with one prompt irq per line (mid-line, where the started-line count is exact).
  task automatic run_frame_prompt(input bit rnd_ready, input int budget);
    int irq_line = beats / W - 1;
    for (int i = 0; i < budget && done_cnt == 0; i++) begin
      ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (beats % W >= 2 && beats % W <= 4 && beats / W > irq_line) begin
        m_irq(beats / W + 1);
        irq_line = beats / W;
        irq = 1'b1;
      end
      cyc();
      irq = 1'b0;
    end
    ready = 1'b1;
  endtask

  task automatic check_frame_end(input string tag);
    check_eq({tag, "_beats"}, beats, m_lines() * W);
    check_eq({tag, "_done_cnt"}, done_cnt, 1);
    check_eq({tag, "_done_lat"}, done_cyc - last_beat_cyc, 1);
    repeat (3) cyc();
    check_eq({tag, "_busy"}, int'(busy), 0);
    check_eq({tag, "_valid"}, int'(dvalid), 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ready = 1'b0; irq = 1'b0;
    beats = 0; done_cnt = 0; cyc_n = 0; gaps = 0; m_irqs = 0;
    first_valid_cyc = -1; track_gaps = 1'b0; prev_stall = 1'b0; prev_data = 8'd0;
    @(negedge clk);
    repeat (3) cyc();
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_done", int'(done), 0);
    check_eq("rst_rd_en", int'(rd_en), 0);
    check_eq("rst_valid", int'(dvalid), 0);
    check_eq("rst_addr", int'(rd_addr), 0);
    check_eq("rst_data", int'(data), 0);
    rst = 1'b0;
    cyc();

    // 1: no irq -> only INIT_LINES lines, back to back, then stall while busy.
    ready = 1'b1; track_gaps = 1'b1;
    new_frame();
    run_until(m_lines() * W, 200);
    repeat (20) cyc();
    check_eq("t1_beats", beats, m_lines() * W);
    check_eq("t1_first_lat", first_valid_cyc, 4);
    check_eq("t1_gaps", gaps, 0);
    check_eq("t1_busy", int'(busy), 1);
    check_eq("t1_valid", int'(dvalid), 0);
    check_eq("t1_done", done_cnt, 0);

    // 2: two irqs while stalled release the remaining lines; address stops at the last pixel.
    track_gaps = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_irq(beats / W);
      irq = 1'b1;
      cyc();
      irq = 1'b0;
      repeat (2) cyc();
    end
    for (int i = 0; i < 300 && done_cnt == 0; i++) cyc();
    check_frame_end("t2");
    check_eq("t2_last_addr", int'(rd_addr), W * H - 1);

    // 3: random back-pressure with prompt irqs.
    new_frame();
    run_frame_prompt(1'b1, 2000);
    check_frame_end("t3");

    // 4: irq coinciding with the first consume, a dropped irq in line 0, no boundary bubbles.
    ready = 1'b1; track_gaps = 1'b1;
    beats = 0; done_cnt = 0; m_irqs = 0; gaps = 0; prev_stall = 1'b0;
    cyc_n = 0; first_valid_cyc = -1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    irq = 1'b1;
    m_irq(1);
    cyc();
    irq = 1'b0;
    run_until(3, 50);
    m_irq(1);
    irq = 1'b1;
    cyc();
    irq = 1'b0;
    run_until(m_lines() * W, 200);
    repeat (20) cyc();
    check_eq("t4_beats", beats, m_lines() * W);
    check_eq("t4_gaps", gaps, 0);
    track_gaps = 1'b0;
    m_irq(beats / W);
    irq = 1'b1;
    cyc();
    irq = 1'b0;
    for (int i = 0; i < 200 && done_cnt == 0; i++) cyc();
    check_frame_end("t4");

    // 5: irqs in IDLE are ignored; extra irqs at full credit are dropped.
    irq = 1'b1;
    repeat (3) cyc();
    irq = 1'b0;
    new_frame();
    run_until(2, 50);
    ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      m_irq(1);
      irq = 1'b1;
      cyc();
    end
    irq = 1'b0;
    ready = 1'b1;
    run_until(m_lines() * W, 300);
    repeat (20) cyc();
    check_eq("t5_beats", beats, m_lines() * W);
    check_eq("t5_busy", int'(busy), 1);

    // 6: reset mid-frame, then a fresh frame from pixel 0.
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    new_frame();
    run_until(10, 50);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check_eq("t6_valid", int'(dvalid), 0);
    check_eq("t6_busy", int'(busy), 0);
    check_eq("t6_rd_en", int'(rd_en), 0);
    check_eq("t6_addr", int'(rd_addr), 0);
    repeat (5) cyc();
    check_eq("t6_no_done", done_cnt, 0);
    check_eq("t6_idle_valid", int'(dvalid), 0);
    new_frame();
    run_frame_prompt(1'b0, 500);
    check_frame_end("t6");

    // 7: a start pulse mid-frame must not disturb anything.
    new_frame();
    run_until(12, 50);
    start = 1'b1;
    cyc();
    start = 1'b0;
    run_frame_prompt(1'b1, 2000);
    check_frame_end("t7");
    repeat (10) cyc();
    check_eq("t7_done_once", done_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
